// File: rtl/fd_instr_queue_pkg.sv
// -----------------------------------------------------------------------------
// fd_instr_queue_pkg
// Shared constants for the Fetch/Decode decoupling queue and its neighbours.
//   NOP       : all-zero instruction word, presented to Decode as a bubble.
//   PC_RESET  : PC value Fetch loads on reset.
//   FDQ_DEPTH : default number of queue entries.
// -----------------------------------------------------------------------------
package fd_instr_queue_pkg;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam int          FDQ_DEPTH = 2;

endpackage : fd_instr_queue_pkg

// File: rtl/fd_instr_queue_fdq_ram.sv
// -----------------------------------------------------------------------------
// fdq_ram
// DEPTH x W storage for the Fetch/Decode queue entries.
// Ports:
//   clk      in  1   rising-edge clock for the write port
//   we_i     in  1   write enable
//   waddr_i  in  AW  write address
//   wdata_i  in  W   write data
//   raddr_i  in  AW  read address (combinational read)
//   rdata_o  out W   read data
// The array has no reset: the queue masks its output while empty, so stale
// contents are never observed.
// -----------------------------------------------------------------------------
module fdq_ram #(
  parameter int DEPTH = 2,
  parameter int AW    = 1,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read port.
  assign rdata_o = mem_q[raddr_i];

endmodule : fdq_ram

// File: rtl/fd_instr_queue.sv
// -----------------------------------------------------------------------------
// fd_instr_queue
// Decoupling queue between the Fetch and Decode stages. Fetch pushes
// {PC, Instr} pairs, Decode pops from the head. Ready_F stalls the Fetch PC.
// Flush empties the queue on redirect/exception.
// Ports:
//   clk      in  1     clock, rising edge
//   reset    in  1     asynchronous, active-low reset
//   Push_F   in  1     Fetch presents {PC_F, Instr_F}
//   PC_F     in  DW    PC of fetched instruction
//   Instr_F  in  DW    fetched instruction word
//   Ready_F  out 1     push can be accepted this cycle
//   Pop_D    in  1     Decode consumes the head entry
//   Flush    in  1     discard all entries and any same-cycle push/pop
//   Valid_D  out 1     head entry valid
//   PC_D     out DW    head PC (0 when empty)
//   Instr_D  out DW    head instruction (NOP when empty)
//   Count    out AW+1  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fd_instr_queue
  import fd_instr_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Push_F,
  input  logic [DW-1:0] PC_F,
  input  logic [DW-1:0] Instr_F,
  output logic          Ready_F,
  input  logic          Pop_D,
  input  logic          Flush,
  output logic          Valid_D,
  output logic [DW-1:0] PC_D,
  output logic [DW-1:0] Instr_D,
  output logic [AW:0]   Count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            empty_s, full_s;
  logic            do_push_s, do_pop_s;
  logic [2*DW-1:0] rdata_s;

  assign empty_s = (count_q == {(AW+1){1'b0}});
  assign full_s  = (count_q == DEPTH_C);

  // Ready_F depends only on registered state and Pop_D, never on Push_F/Flush.
  assign Ready_F   = ~full_s | Pop_D;
  assign do_pop_s  = Pop_D  & ~empty_s & ~Flush;
  assign do_push_s = Push_F & Ready_F  & ~Flush;

  // Next-state for pointers and occupancy; Flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      // Pointers wrap by natural AW-bit overflow (DEPTH is a power of two).
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
    end
  end

  // Pointer and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fdq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (2*DW)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i ({PC_F, Instr_F}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Head is masked while empty so Decode sees a bubble (PC 0, NOP).
  assign Valid_D = ~empty_s;
  assign PC_D    = empty_s ? {DW{1'b0}} : rdata_s[2*DW-1:DW];
  assign Instr_D = empty_s ? DW'(NOP)   : rdata_s[DW-1:0];
  assign Count   = count_q;

endmodule : fd_instr_queue

// File: tb/tb_fd_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_fd_instr_queue
// Self-checking bench: a queue-based reference model tracks the expected
// contents; every falling edge compares all outputs against it. Directed
// sequences also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_fd_instr_queue;

  localparam int DEPTH = 2;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Push_F = 1'b0;
  logic [DW-1:0] PC_F = '0;
  logic [DW-1:0] Instr_F = '0;
  logic          Ready_F;
  logic          Pop_D = 1'b0;
  logic          Flush = 1'b0;
  logic          Valid_D;
  logic [DW-1:0] PC_D;
  logic [DW-1:0] Instr_D;
  logic [1:0]    Count;

  int tests = 0;
  int fails = 0;

  logic [63:0] model_q[$];

  fd_instr_queue #(.DEPTH(DEPTH), .AW(1), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .Push_F  (Push_F),
    .PC_F    (PC_F),
    .Instr_F (Instr_F),
    .Ready_F (Ready_F),
    .Pop_D   (Pop_D),
    .Flush   (Flush),
    .Valid_D (Valid_D),
    .PC_D    (PC_D),
    .Instr_D (Instr_D),
    .Count   (Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {PC, Instr} with capacity DEPTH.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else if (Flush) begin
      model_q.delete();
    end else begin
      bit can_push;
      can_push = (model_q.size() < DEPTH) || Pop_D;
      if (Pop_D && model_q.size() > 0) void'(model_q.pop_front());
      if (Push_F && can_push) model_q.push_back({PC_F, Instr_F});
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [63:0] head;
    bit          has;
    has  = model_q.size() > 0;
    head = has ? model_q[0] : 64'h0;
    check("valid", {63'h0, Valid_D}, {63'h0, has});
    check("ready", {63'h0, Ready_F}, {63'h0, ((model_q.size() < DEPTH) || Pop_D)});
    check("count", {62'h0, Count}, 64'(model_q.size()));
    check("pc",    {32'h0, PC_D},    {32'h0, head[63:32]});
    check("instr", {32'h0, Instr_D}, {32'h0, head[31:0]});
  end

  // One cycle with the given inputs; returns 1 time unit after the edge with inputs idle.
  task automatic step(input bit push, input logic [31:0] pc, input logic [31:0] ins,
                      input bit pop, input bit flush);
    Push_F  = push;
    PC_F    = pc;
    Instr_F = ins;
    Pop_D   = pop;
    Flush   = flush;
    @(posedge clk);
    #1;
    Push_F = 1'b0;
    Pop_D  = 1'b0;
    Flush  = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    // Reset state.
    check("rst_valid", {63'h0, Valid_D}, 64'h0);
    check("rst_ready", {63'h0, Ready_F}, 64'h1);
    check("rst_count", {62'h0, Count},   64'h0);
    check("rst_instr", {32'h0, Instr_D}, 64'h0);
    check("rst_pc",    {32'h0, PC_D},    64'h0);

    // Fill and drain.
    step(1'b1, 32'h3000, 32'h24010001, 1'b0, 1'b0);
    check("fill1_pc", {32'h0, PC_D}, 64'h3000);
    step(1'b1, 32'h3004, 32'h24020002, 1'b0, 1'b0);
    check("full_count", {62'h0, Count},   64'h2);
    check("full_ready", {63'h0, Ready_F}, 64'h0);
    check("full_instr", {32'h0, Instr_D}, 64'h24010001);
    step(1'b1, 32'h3099, 32'h0, 1'b0, 1'b0);   // dropped: full, no pop
    check("drop_count", {62'h0, Count}, 64'h2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pop1_pc", {32'h0, PC_D}, 64'h3004);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pop2_valid", {63'h0, Valid_D}, 64'h0);

    // Full pass-through.
    step(1'b1, 32'h3000, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h3008, 32'h33, 1'b1, 1'b0);
    check("pass_count", {62'h0, Count}, 64'h2);
    check("pass_pc",    {32'h0, PC_D},  64'h3004);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pass_next_pc", {32'h0, PC_D}, 64'h3008);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pass_empty", {62'h0, Count}, 64'h0);

    // Flush priority.
    step(1'b1, 32'h300c, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h3010, 32'h55, 1'b1, 1'b1);
    check("flush_count", {62'h0, Count},   64'h0);
    check("flush_valid", {63'h0, Valid_D}, 64'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_stays", {63'h0, Valid_D}, 64'h0);

    // Async reset mid-stream.
    step(1'b1, 32'h3020, 32'h66, 1'b0, 1'b0);
    step(1'b1, 32'h3024, 32'h77, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {63'h0, Valid_D}, 64'h0);
    check("arst_count", {62'h0, Count},   64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b1, 32'h3000, 32'h88, 1'b0, 1'b0);
    check("arst_push_pc", {32'h0, PC_D}, 64'h3000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wrap with alternating push/pop pairs.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h3100 + 32'(4*i), 32'(i), 1'b0, 1'b0);
      check("wrap_pc", {32'h0, PC_D}, 64'(32'h3100 + 32'(4*i)));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("empty_pop_count", {62'h0, Count}, 64'h0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fd_instr_queue
